// File: rtl/hdmi_clk_sequencer.sv
// Waits for a synchronised PLL lock plus a settle interval, then releases the pixel
// pipeline reset and emits divide-by-DIV pixel enable / serializer load strobes.
module hdmi_clk_sequencer #(
  parameter int unsigned DIV           = 5,
  parameter int unsigned SETTLE_CYCLES = 1024,
  parameter int unsigned SYNC_STAGES   = 2
) (
  input  logic       clkin,
  input  logic       reset,
  input  logic       pll_lock,
  output logic       pix_ce,
  output logic       load,
  output logic [2:0] slot,
  output logic       pix_rst,
  output logic       running,
  output logic       lock_lost
);

  localparam int unsigned CntW = $clog2(SETTLE_CYCLES + 1);
  localparam logic [CntW-1:0] CntLast = CntW'(SETTLE_CYCLES - 1);
  localparam logic [2:0] SlotLast = 3'(DIV - 1);

  typedef enum logic [1:0] {
    StWaitLock,
    StSettle,
    StRun
  } state_e;

  state_e                 state_q, state_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic [2:0]             slot_q, slot_d;
  logic                   lock_lost_q, lock_lost_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   lock_s;

  assign lock_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    slot_d      = slot_q;
    lock_lost_d = lock_lost_q;
    case (state_q)
      StWaitLock: begin
        cnt_d  = '0;
        slot_d = '0;
        if (lock_s) state_d = StSettle;
      end
      StSettle: begin
        if (!lock_s) begin
          state_d = StWaitLock;
          cnt_d   = '0;
        end else if (cnt_q == CntLast) begin
          state_d = StRun;
          cnt_d   = '0;
          slot_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      StRun: begin
        if (!lock_s) begin
          state_d     = StWaitLock;
          lock_lost_d = 1'b1;
          slot_d      = '0;
        end else begin
          slot_d = (slot_q == SlotLast) ? 3'd0 : slot_q + 3'd1;
        end
      end
      default: state_d = StWaitLock;
    endcase
  end

  // Strobes are registered from next state so they line up with slot_q.
  always_ff @(posedge clkin) begin
    if (reset) begin
      sync_q      <= '0;
      state_q     <= StWaitLock;
      cnt_q       <= '0;
      slot_q      <= '0;
      lock_lost_q <= 1'b0;
      pix_ce      <= 1'b0;
      load        <= 1'b0;
      pix_rst     <= 1'b1;
      running     <= 1'b0;
    end else begin
      sync_q      <= {sync_q[SYNC_STAGES-2:0], pll_lock};
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      slot_q      <= slot_d;
      lock_lost_q <= lock_lost_d;
      pix_ce      <= (state_d == StRun) && (slot_d == SlotLast);
      load        <= (state_d == StRun) && (slot_d == 3'd0);
      pix_rst     <= (state_d != StRun);
      running     <= (state_d == StRun);
    end
  end

  assign slot      = slot_q;
  assign lock_lost = lock_lost_q;

endmodule

// File: tb/tb_hdmi_clk_sequencer.sv
// Directed bench for hdmi_clk_sequencer: DIV=5 main instance plus DIV=2 and DIV=8
// instances sharing stimulus, all with a 16-cycle settle interval.
module tb_hdmi_clk_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       pll_lock;
  logic       pix_ce, load, pix_rst, running, lock_lost;
  logic [2:0] slot;
  logic       pix_ce2, load2, pix_rst2, running2, lock_lost2;
  logic [2:0] slot2;
  logic       pix_ce8, load8, pix_rst8, running8, lock_lost8;
  logic [2:0] slot8;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  hdmi_clk_sequencer #(.DIV(5), .SETTLE_CYCLES(16), .SYNC_STAGES(2)) dut (
    .clkin(clk), .reset(reset), .pll_lock(pll_lock), .pix_ce(pix_ce), .load(load),
    .slot(slot), .pix_rst(pix_rst), .running(running), .lock_lost(lock_lost)
  );

  hdmi_clk_sequencer #(.DIV(2), .SETTLE_CYCLES(16), .SYNC_STAGES(2)) dut2 (
    .clkin(clk), .reset(reset), .pll_lock(pll_lock), .pix_ce(pix_ce2), .load(load2),
    .slot(slot2), .pix_rst(pix_rst2), .running(running2), .lock_lost(lock_lost2)
  );

  hdmi_clk_sequencer #(.DIV(8), .SETTLE_CYCLES(16), .SYNC_STAGES(2)) dut8 (
    .clkin(clk), .reset(reset), .pll_lock(pll_lock), .pix_ce(pix_ce8), .load(load8),
    .slot(slot8), .pix_rst(pix_rst8), .running(running8), .lock_lost(lock_lost8)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Inputs are driven and outputs sampled 1ns after the active edge.
  task automatic tick(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic check_reset_vals(input string tag);
    check_eq({tag, "_running"}, 32'(running), 0);
    check_eq({tag, "_pix_rst"}, 32'(pix_rst), 1);
    check_eq({tag, "_load"}, 32'(load), 0);
    check_eq({tag, "_pix_ce"}, 32'(pix_ce), 0);
    check_eq({tag, "_slot"}, 32'(slot), 0);
    check_eq({tag, "_lock_lost"}, 32'(lock_lost), 0);
  endtask

  // Drives lock high and checks running rises on exactly the 19th edge.
  task automatic check_latency(input string tag);
    int early;
    early = 0;
    for (int i = 0; i < 18; i++) begin
      tick(1);
      if (running) early++;
    end
    check_eq({tag, "_early_run"}, 32'(early), 0);
    tick(1);
    check_eq({tag, "_running"}, 32'(running), 1);
    check_eq({tag, "_pix_rst"}, 32'(pix_rst), 0);
    check_eq({tag, "_load"}, 32'(load), 1);
    check_eq({tag, "_slot"}, 32'(slot), 0);
  endtask

  initial begin
    int ce_count;
    int adjacent;
    logic prev_ce;
    reset    = 1'b1;
    pll_lock = 1'b0;
    @(posedge clk);
    #1;
    tick(3);
    check_reset_vals("rst");

    // Lock-to-run latency
    reset    = 1'b0;
    pll_lock = 1'b1;
    check_latency("t1");
    check_eq("t1_run2", 32'(running2), 1);
    check_eq("t1_run8", 32'(running8), 1);

    // Steady RUN pattern on all three divisors
    ce_count = 0;
    adjacent = 0;
    prev_ce  = 1'b0;
    for (int i = 1; i <= 50; i++) begin
      tick(1);
      check_eq("t2_slot", 32'(slot), 32'(i % 5));
      check_eq("t2_load", 32'(load), 32'((i % 5) == 0));
      check_eq("t2_pix_ce", 32'(pix_ce), 32'((i % 5) == 4));
      check_eq("t6_slot2", 32'(slot2), 32'(i % 2));
      check_eq("t6_load2", 32'(load2), 32'((i % 2) == 0));
      check_eq("t6_pix_ce2", 32'(pix_ce2), 32'((i % 2) == 1));
      check_eq("t6_slot8", 32'(slot8), 32'(i % 8));
      check_eq("t6_pix_ce8", 32'(pix_ce8), 32'((i % 8) == 7));
      check_eq("t6_load8", 32'(load8), 32'((i % 8) == 0));
      if (pix_ce) ce_count++;
      if (pix_ce && prev_ce) adjacent++;
      prev_ce = pix_ce;
    end
    check_eq("t2_ce_count", 32'(ce_count), 10);
    check_eq("t2_ce_adjacent", 32'(adjacent), 0);

    // Lock drop in RUN, then relock
    pll_lock = 1'b0;
    tick(2);
    check_eq("t4_still_running", 32'(running), 1);
    tick(1);
    check_eq("t4_running", 32'(running), 0);
    check_eq("t4_pix_rst", 32'(pix_rst), 1);
    check_eq("t4_lock_lost", 32'(lock_lost), 1);
    check_eq("t4_load", 32'(load), 0);
    check_eq("t4_pix_ce", 32'(pix_ce), 0);
    check_eq("t4_slot", 32'(slot), 0);
    tick(2);
    pll_lock = 1'b1;
    check_latency("t4_relock");
    check_eq("t4_lock_lost_kept", 32'(lock_lost), 1);

    // Reset mid-RUN at slot 2
    tick(2);
    check_eq("t5_slot", 32'(slot), 2);
    reset = 1'b1;
    tick(1);
    check_reset_vals("t5");
    reset = 1'b0;
    check_latency("t5_release");

    // Lock glitch during SETTLE restarts the full settle interval
    reset    = 1'b1;
    pll_lock = 1'b0;
    tick(1);
    reset = 1'b0;
    tick(4);
    pll_lock = 1'b1;
    tick(11);
    check_eq("t3_settling", 32'(running), 0);
    pll_lock = 1'b0;
    tick(3);
    check_eq("t3_glitch_run", 32'(running), 0);
    pll_lock = 1'b1;
    check_latency("t3_resettle");
    check_eq("t3_lock_lost", 32'(lock_lost), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
